// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg -- shared PID constants and IN-buffer state encoding for the
// full-speed USB endpoint blocks.
package usb_fs_pkg;

  // Endpoint IN buffer life cycle.
  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,  // endpoint logic is loading the payload
    ST_READY    = 2'd1,  // payload committed, waiting for an IN token
    ST_SEND     = 2'd2,  // transmitter is draining the payload
    ST_WAIT_ACK = 2'd3   // packet sent, waiting for the host handshake
  } in_buf_state_e;

  // Packet identifiers (4-bit PID field, check nibble added by the transmitter).
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  // Data PID selected by the current data toggle.
  function automatic logic [3:0] data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_fs_sdp_ram.sv
// usb_fs_sdp_ram -- simple dual-port payload RAM, DEPTH x 8, one write port
// and one registered read port sharing a single clock.
module usb_fs_sdp_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Write port.
  // NOTE: the array itself is never reset so it maps onto block RAM; only
  // the read register below is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb_fs_in_buf.sv
// usb_fs_in_buf -- single-packet IN endpoint buffer for a full-speed USB
// device. Endpoint logic fills a linear buffer, commits it, and the buffer
// answers the next IN token with DATA0/DATA1 (or NAK while still filling),
// then tracks the host handshake and the data toggle.
//
// Build option: define USB_FS_IN_RETRY_EN to keep the payload after a NAK or
// timeout and resend it on the next IN token; otherwise the payload is dropped.
module usb_fs_in_buf
  import usb_fs_pkg::*;
#(
  parameter int DEPTH = 64  // max payload bytes, power of two, 8..1024
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       commit,
  input  logic       in_token,
  input  logic       ack_rcvd,
  input  logic       nak_or_timeout,
  input  logic       toggle_set1,
  output logic       pkt_start,
  output logic [3:0] pid,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data,
  input  logic       pkt_end,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // count/pointers must be able to hold DEPTH
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  in_buf_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;    // bytes stored; also the write pointer
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          toggle_q, toggle_d;
  logic          pkt_start_q, pkt_start_d;
  logic [3:0]    pid_q, pid_d;
  logic          avail_q, avail_d;
  logic          wr_fire;
  logic          get_fire;

  // The buffer is linear and restarts at zero on every return to FILL, so
  // the write pointer always equals the byte count.
  assign wr_ready = !reset && (state_q == ST_FILL) && (count_q < FULL);
  assign wr_fire  = wr_valid && wr_ready;
  assign get_fire = tx_data_get && avail_q && (state_q == ST_SEND);

  assign pkt_start     = pkt_start_q;
  assign pid           = pid_q;
  assign tx_data_avail = avail_q;
  assign busy          = (state_q != ST_FILL);

  // Next-state, pointer, toggle and transmitter-handshake logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    toggle_d    = toggle_q;
    pkt_start_d = 1'b0;
    pid_d       = pid_q;

    case (state_q)
      ST_FILL: begin
        if (wr_fire) count_d = count_q + ONE;
        // A commit in the same cycle as an accepted write includes that byte.
        if (commit) state_d = ST_READY;
        if (in_token) begin
          pkt_start_d = 1'b1;
          pid_d       = PID_NAK;
        end
      end
      ST_READY: begin
        if (in_token) begin
          state_d     = ST_SEND;
          pkt_start_d = 1'b1;
          pid_d       = data_pid(toggle_q);
          rd_ptr_d    = '0;
        end
      end
      ST_SEND: begin
        if (get_fire) rd_ptr_d = rd_ptr_q + ONE;
        if (pkt_end)  state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_rcvd) begin
          toggle_d = ~toggle_q;
          count_d  = '0;
          rd_ptr_d = '0;
          state_d  = ST_FILL;
        end else if (nak_or_timeout) begin
`ifdef USB_FS_IN_RETRY_EN
          rd_ptr_d = '0;
          state_d  = ST_READY;
`else
          count_d  = '0;
          rd_ptr_d = '0;
          state_d  = ST_FILL;
`endif
        end
      end
      default: state_d = ST_FILL;
    endcase

    // SETUP handling overrides any ACK-driven toggle flip.
    if (toggle_set1) toggle_d = 1'b1;

    // Computed from next-cycle values so availability and RAM read data
    // both change on the same edge.
    avail_d = (state_d == ST_SEND) && (rd_ptr_d != count_d);
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      toggle_q    <= 1'b0;
      pkt_start_q <= 1'b0;
      pid_q       <= '0;
      avail_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      toggle_q    <= toggle_d;
      pkt_start_q <= pkt_start_d;
      pid_q       <= pid_d;
      avail_q     <= avail_d;
    end
  end

  // Payload storage; the read address runs one step ahead so tx_data tracks
  // rd_ptr with a single cycle of latency.
  usb_fs_sdp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk_48mhz),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (state_d == ST_SEND),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (tx_data)
  );

endmodule
